// File: rtl/core_command_decoder.sv
// core_command_decoder
//
// Host-side bus master for the core register bus. Assembles command frames
// from the serial link receiver byte stream, drives instruction/address/value
// to the core interfaces, and returns READ data to the link transmitter as
// four bytes, MSB first.
//
// Parameters:
//   READ_LATENCY   - cycles READ is held on the bus before output_value is sampled (>=1)
//   TIMEOUT_CYCLES - idle cycles allowed between bytes of one frame (>=2)
//   NAK_BYTE       - response byte for an unknown opcode
//
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   rx_byte/valid/ready - byte stream from the link receiver
//   tx_byte/valid/ready - response byte stream to the link transmitter
//   instruction         - bus opcode (NOP/WRITE/READ)
//   address, value      - bus address and write data, updated only on frame completion
//   output_value        - bus read data from the addressed core interface
//   busy                - high whenever the decoder is not in IDLE
module core_command_decoder #(
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  instruction,
    output logic [23:0] address,
    output logic [31:0] value,
    input  logic [31:0] output_value,
    output logic        busy
);

    // Bus opcode encoding shared with the core interfaces.
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_VALUE,
        BUS_WRITE,
        BUS_READ,
        SEND_DATA,
        SEND_NAK
    } state_t;

    state_t           state;
    logic             is_write;
    logic [23:0]      addr_sr;   // partial address, kept off the bus until frame completes
    logic [23:0]      val_sr;    // first three value bytes; the fourth arrives with the last transfer
    logic [23:0]      rd_data;   // remaining read-response bytes still to send
    logic [1:0]       byte_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             rx_fire;
    logic             tx_fire;

    assign rx_ready = (state == IDLE) || (state == GET_ADDR) || (state == GET_VALUE);
    assign busy     = (state != IDLE);
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            addr_sr     <= '0;
            val_sr      <= '0;
            rd_data     <= '0;
            byte_cnt    <= '0;
            lat_cnt     <= '0;
            tmo_cnt     <= '0;
            instruction <= OP_NOP;
            address     <= '0;
            value       <= '0;
            tx_byte     <= '0;
            tx_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        case (rx_byte)
                            OP_WRITE, OP_READ: begin
                                is_write <= (rx_byte == OP_WRITE);
                                byte_cnt <= '0;
                                tmo_cnt  <= '0;
                                state    <= GET_ADDR;
                            end
                            OP_NOP: ;
                            default: begin
                                tx_byte  <= NAK_BYTE;
                                tx_valid <= 1'b1;
                                state    <= SEND_NAK;
                            end
                        endcase
                    end
                end

                GET_ADDR: begin
                    if (rx_fire) begin
                        tmo_cnt <= '0;
                        addr_sr <= {addr_sr[15:0], rx_byte};
                        if (byte_cnt == 2'd2) begin
                            byte_cnt <= '0;
                            if (is_write) begin
                                state <= GET_VALUE;
                            end else begin
                                address     <= {addr_sr[15:0], rx_byte};
                                instruction <= OP_READ;
                                lat_cnt     <= '0;
                                state       <= BUS_READ;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Sender went quiet mid-frame: drop it silently.
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                GET_VALUE: begin
                    if (rx_fire) begin
                        tmo_cnt <= '0;
                        val_sr  <= {val_sr[15:0], rx_byte};
                        if (byte_cnt == 2'd3) begin
                            address     <= addr_sr;
                            value       <= {val_sr, rx_byte};
                            instruction <= OP_WRITE;
                            state       <= BUS_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                BUS_WRITE: begin
                    instruction <= OP_NOP;
                    state       <= IDLE;
                end

                BUS_READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        // Sample read data on the last READ cycle; the MSB goes out at once.
                        instruction <= OP_NOP;
                        tx_byte     <= output_value[31:24];
                        rd_data     <= output_value[23:0];
                        tx_valid    <= 1'b1;
                        byte_cnt    <= '0;
                        state       <= SEND_DATA;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                SEND_DATA: begin
                    if (tx_fire) begin
                        if (byte_cnt == 2'd3) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_byte  <= rd_data[23:16];
                            rd_data  <= {rd_data[15:0], 8'h00};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                SEND_NAK: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    instruction <= OP_NOP;
                    tx_valid    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/core_command_decoder.md
# core_command_decoder

Host-side initiator for the core register bus. It accepts a byte stream from the serial link receiver, assembles command frames, and drives `instruction`/`address`/`value` into the `core_interface` instances. For READ commands it captures `output_value` and returns it to the link transmitter as four bytes. It is the single bus master between the comms PHY and all core interfaces.

## Interface
Parameters:
- `READ_LATENCY`, 2: cycles READ is held on the bus before `output_value` is sampled (≥1).
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles allowed between bytes of one frame before the frame is abandoned (≥2).
- `NAK_BYTE`, 8'h15: byte returned for an unknown opcode.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_byte`  in  8  byte from link receiver.
- `rx_valid`  in  1  `rx_byte` valid.
- `rx_ready`  out  1  decoder accepts a byte this cycle.
- `tx_byte`  out  8  response byte to link transmitter.
- `tx_valid`  out  1  `tx_byte` valid.
- `tx_ready`  in  1  transmitter accepts `tx_byte`.
- `instruction`  out  8  bus opcode (TitanComms::instructions encoding).
- `address`  out  24  bus address.
- `value`  out  32  bus write data.
- `output_value`  in  32  bus read data from the addressed core interface.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- A byte transfers when `rx_valid && rx_ready` is true. A byte transfers on `tx_valid && tx_ready`.
- Frame formats:
  - WRITE: opcode, addr[23:16], addr[15:8], addr[7:0], val[31:24], val[23:16], val[15:8], val[7:0].
  - READ: opcode, addr[23:16], addr[15:8], addr[7:0].
  - NOP: opcode only. It is consumed and produces no response and no bus cycle.
- States:
  - IDLE: `rx_ready`=1. Opcode WRITE or READ → GET_ADDR. NOP → stay. Any other value → SEND_NAK.
  - GET_ADDR: `rx_ready`=1. Shifts in 3 bytes, MSB first. After the 3rd byte: WRITE → GET_VALUE, READ → BUS_READ.
  - GET_VALUE: `rx_ready`=1. Shifts in 4 bytes, MSB first. After the 4th byte → BUS_WRITE.
  - BUS_WRITE: `instruction`=WRITE for exactly 1 cycle → IDLE.
  - BUS_READ: `instruction`=READ for `READ_LATENCY` cycles. `output_value` is latched on the last of these cycles → SEND_DATA.
  - SEND_DATA: sends 4 bytes MSB first. After the 4th handshake → IDLE.
  - SEND_NAK: sends `NAK_BYTE` once → IDLE.
- `rx_ready`=0 in BUS_WRITE, BUS_READ, SEND_DATA and SEND_NAK. Bytes offered in those states are not consumed; the upstream holds them.
- `instruction`=NOP in every state except BUS_WRITE and BUS_READ.
- `address` and `value` update only when a frame completes and then hold until the next frame. Partial frames never disturb the bus outputs; assembly uses internal shift registers.
- Timeout: in GET_ADDR or GET_VALUE, a counter increments on each cycle without a transfer and clears on a transfer. When it reaches `TIMEOUT_CYCLES`, the state returns to IDLE, the partial frame is discarded, and no response or bus cycle is produced.
- Reset (any time, including mid-frame or mid-response): state goes to IDLE; `instruction`=NOP, `address`=0, `value`=0, `tx_valid`=0, `tx_byte`=0, `busy`=0, timeout counter 0. `rx_ready`=1 after reset because the state is IDLE.

## Timing
- Let the cycle of the final frame-byte transfer be N.
- WRITE:
  - Cycle N+1: `instruction`=WRITE, with the new `address` and `value`.
  - Cycle N+2: `instruction`=NOP, `rx_ready`=1.
- READ:
  - Cycles N+1 … N+`READ_LATENCY`: `instruction`=READ, with the new `address`.
  - Cycle N+`READ_LATENCY`+1: `instruction`=NOP, `tx_valid`=1, `tx_byte`=data[31:24].
- SEND_DATA:
  - Each byte holds until its handshake.
  - The next byte is presented in the cycle after the handshake. `tx_valid` stays 1 between bytes when `tx_ready` is continuously high.
  - With `tx_ready` tied high, the response takes 4 cycles.
- Unknown opcode at cycle N: `tx_valid`=1 with `NAK_BYTE` at N+1.
- Back-to-back frames: the first byte of the next frame can transfer in the cycle after return to IDLE.
- Outputs are registered. `rx_ready` and `busy` are decoded from the state register.

## Test plan
- After reset: check `instruction`=NOP, `address`=0, `value`=0, `tx_valid`=0, `rx_ready`=1. Send WRITE, 00 00 00, 00 00 00 07 → exactly one cycle of WRITE with `address`=0 and `value`=7, then NOP. No tx bytes.
- WRITE to addr 1, value 3; then READ addr 2 with `output_value` driven to 32'h0000000A → READ held for 2 cycles, then tx bytes 00 00 00 0A in order, with `tx_ready` toggling 1/0 each cycle.
- Opcode 8'hFF → single tx byte 8'h15, no bus activity. An immediately following NOP → no response, `busy` stays 0.
- With `TIMEOUT_CYCLES`=16: send READ, 00, then stall 16 cycles → return to IDLE with no bus cycle. A new READ 00 00 03 then works normally.
- Assert `reset` during the 2nd tx byte of a READ response → `tx_valid`=0 immediately (asynchronous), all outputs at reset values, and the next frame decodes correctly.
- Offer rx bytes during BUS_READ and SEND_DATA → `rx_ready`=0 and the bytes are not consumed. After IDLE, the held byte is accepted as the next opcode.
